// File: rtl/ic_pkg.sv
// Shared definitions for the buffered multicast interconnect: default word
// width, source-select width derivation and taken-bit matrix indexing.
package ic_pkg;

  localparam int W_DEF = 128;

  function automatic int bmvua(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Taken matrix is stored source-major: bit (src, rx) at src*n + rx.
  function automatic int tk_idx(input int src, input int rx, input int n);
    return src * n + rx;
  endfunction

endpackage

// File: rtl/ic_fifo.sv
// Per-source word FIFO with combinational head, wrap-bit pointers and a
// synchronous flush that outranks push and pop.
module ic_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign dout      = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = push && !full && !clr;
  assign w_do_pop  = pop && !empty && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage carries no reset; only slots behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ic_mcast_fifo.sv
// Buffered multicast interconnect: one FIFO per source, one registered
// valid/ready output per receiver; a head retires once all subscribers took it.
module ic_mcast_fifo
  import ic_pkg::*;
#(
  parameter int NMVU  = 8,
  parameter int W     = W_DEF,
  parameter int DEPTH = 4,
  localparam int BMVUA = bmvua(NMVU)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_clr,
  input  logic [NMVU-1:0]       send_en,
  input  logic [NMVU*W-1:0]     send_word,
  output logic [NMVU-1:0]       send_rdy,
  output logic [NMVU-1:0]       ovf,
  input  logic [NMVU-1:0]       recv_on,
  input  logic [NMVU*BMVUA-1:0] recv_from,
  output logic [NMVU-1:0]       recv_en,
  output logic [NMVU*W-1:0]     recv_word,
  input  logic [NMVU-1:0]       recv_rdy
);

  logic [W-1:0]         w_head [NMVU];
  logic [BMVUA-1:0]     w_src  [NMVU];
  logic [NMVU-1:0]      w_empty;
  logic [NMVU-1:0]      w_full;
  logic [NMVU-1:0]      w_pop;
  logic [NMVU-1:0]      w_load;
  logic [NMVU-1:0]      w_sub_any;
  logic [NMVU-1:0]      w_covered;
  logic [NMVU*NMVU-1:0] r_taken;
  logic [NMVU-1:0]      r_ovf;
  logic [NMVU-1:0]      r_recv_en;
  logic [NMVU*W-1:0]    r_recv_word;

  assign send_rdy  = ~w_full;
  assign ovf       = r_ovf;
  assign recv_en   = r_recv_en;
  assign recv_word = r_recv_word;

  for (genvar gi = 0; gi < NMVU; gi++) begin : g_src
    ic_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (ic_clr),
      .push  (send_en[gi]),
      .pop   (w_pop[gi]),
      .din   (send_word[gi*W +: W]),
      .dout  (w_head[gi]),
      .empty (w_empty[gi]),
      .full  (w_full[gi])
    );
  end

  for (genvar gj = 0; gj < NMVU; gj++) begin : g_rx
    assign w_src[gj]  = recv_from[gj*BMVUA +: BMVUA];
    // A receiver loads only a head it has not already taken, into a free or draining output reg.
    assign w_load[gj] = recv_on[gj] && (int'(w_src[gj]) < NMVU)
                        && !w_empty[w_src[gj]]
                        && !r_taken[tk_idx(int'(w_src[gj]), gj, NMVU)]
                        && (!r_recv_en[gj] || recv_rdy[gj]);
  end

  // Head pops once every current subscriber has it, either earlier or this cycle.
  always_comb begin
    w_sub_any = '0;
    w_covered = '1;
    for (int i = 0; i < NMVU; i++) begin
      for (int j = 0; j < NMVU; j++) begin
        if (recv_on[j] && (w_src[j] == BMVUA'(i))) begin
          w_sub_any[i] = 1'b1;
          if (!(r_taken[tk_idx(i, j, NMVU)] || w_load[j])) w_covered[i] = 1'b0;
        end
      end
    end
    w_pop = w_sub_any & w_covered & ~w_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken <= '0;
    end else if (ic_clr) begin
      r_taken <= '0;
    end else begin
      for (int i = 0; i < NMVU; i++) begin
        for (int j = 0; j < NMVU; j++) begin
          if (w_pop[i]) r_taken[tk_idx(i, j, NMVU)] <= 1'b0;
          else if (w_load[j] && (w_src[j] == BMVUA'(i))) r_taken[tk_idx(i, j, NMVU)] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_recv_en   <= '0;
      r_recv_word <= '0;
    end else if (ic_clr) begin
      r_recv_en   <= '0;
      r_recv_word <= '0;
    end else begin
      for (int j = 0; j < NMVU; j++) begin
        if (w_load[j]) begin
          r_recv_en[j]           <= 1'b1;
          r_recv_word[j*W +: W]  <= w_head[w_src[j]];
        end else if (recv_rdy[j]) begin
          r_recv_en[j]           <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_ovf <= '0;
    else if (ic_clr) r_ovf <= '0;
    else             r_ovf <= r_ovf | (send_en & w_full);
  end

endmodule

// File: tb/tb_ic_mcast_fifo.sv
// Randomised and directed bench for ic_mcast_fifo against a queue-based
// reference of the multicast delivery rules.
module tb_ic_mcast_fifo;

  localparam int N     = 8;
  localparam int W     = 128;
  localparam int DEPTH = 4;
  localparam int B     = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ic_clr = 1'b0;
  logic [N-1:0]   send_en = '0;
  logic [N*W-1:0] send_word = '0;
  logic [N-1:0]   send_rdy;
  logic [N-1:0]   ovf;
  logic [N-1:0]   recv_on = '0;
  logic [N*B-1:0] recv_from = '0;
  logic [N-1:0]   recv_en;
  logic [N*W-1:0] recv_word;
  logic [N-1:0]   recv_rdy = '0;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: per-source queues, per-source set of receivers holding the head.
  logic [W-1:0] mq [N][$];
  bit   [N-1:0] mtk [N];
  bit   [N-1:0] men;
  bit   [N-1:0] movf;
  logic [W-1:0] mword [N];

  ic_mcast_fifo #(.NMVU(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ic_clr(ic_clr),
    .send_en(send_en), .send_word(send_word), .send_rdy(send_rdy), .ovf(ovf),
    .recv_on(recv_on), .recv_from(recv_from),
    .recv_en(recv_en), .recv_word(recv_word), .recv_rdy(recv_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      mtk[i]   = '0;
      mword[i] = '0;
    end
    men  = '0;
    movf = '0;
  endtask

  // Advance the reference by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit [N-1:0] ld;
    bit [N-1:0] pop;
    bit [N-1:0] pushok;
    int         src [N];
    bit         sub;
    bit         cov;
    if (ic_clr) begin
      model_reset();
      return;
    end
    for (int j = 0; j < N; j++) begin
      src[j] = int'(recv_from[j*B +: B]);
      ld[j]  = recv_on[j] && (mq[src[j]].size() > 0) && !mtk[src[j]][j] && (!men[j] || recv_rdy[j]);
    end
    for (int i = 0; i < N; i++) begin
      sub = 1'b0;
      cov = 1'b1;
      for (int j = 0; j < N; j++) begin
        if (recv_on[j] && src[j] == i) begin
          sub = 1'b1;
          if (!(mtk[i][j] || ld[j])) cov = 1'b0;
        end
      end
      pop[i]    = sub && cov && (mq[i].size() > 0);
      pushok[i] = send_en[i] && (mq[i].size() < DEPTH);
      if (send_en[i] && mq[i].size() >= DEPTH) movf[i] = 1'b1;
    end
    for (int j = 0; j < N; j++) begin
      if (ld[j]) begin
        men[j]           = 1'b1;
        mword[j]         = mq[src[j]][0];
        mtk[src[j]][j]   = 1'b1;
      end else if (recv_rdy[j]) begin
        men[j] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (pop[i]) begin
        void'(mq[i].pop_front());
        mtk[i] = '0;
      end
      if (pushok[i]) mq[i].push_back(send_word[i*W +: W]);
    end
  endtask

  task automatic check_all(input string ph);
    bit [N-1:0] rdy_exp;
    for (int i = 0; i < N; i++) rdy_exp[i] = (mq[i].size() < DEPTH);
    chk({ph, ".recv_en"}, W'(recv_en), W'(men));
    chk({ph, ".send_rdy"}, W'(send_rdy), W'(rdy_exp));
    chk({ph, ".ovf"}, W'(ovf), W'(movf));
    for (int j = 0; j < N; j++)
      if (men[j]) chk({ph, ".recv_word"}, recv_word[j*W +: W], mword[j]);
  endtask

  task automatic tick(input string ph);
    model_step();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic idle_inputs();
    ic_clr    = 1'b0;
    send_en   = '0;
    send_word = '0;
    recv_on   = '0;
    recv_from = '0;
    recv_rdy  = '0;
  endtask

  task automatic subscribe(input int j, input int s);
    recv_on[j]          = 1'b1;
    recv_from[j*B +: B] = B'(s);
  endtask

  task automatic push(input int i, input logic [W-1:0] d);
    send_en[i]          = 1'b1;
    send_word[i*W +: W] = d;
  endtask

  task automatic flush();
    idle_inputs();
    ic_clr = 1'b1;
    tick("flush");
    ic_clr = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [W-1:0] words [16];
  int           cnt;

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    chk("reset.recv_en", W'(recv_en), '0);
    chk("reset.recv_word", recv_word[W-1:0], '0);
    chk("reset.send_rdy", W'(send_rdy), W'(8'hFF));
    chk("reset.ovf", W'(ovf), '0);
    rst = 1'b0;

    // Unicast latency.
    subscribe(1, 0);
    recv_rdy = '1;
    push(0, W'(8'hA5));
    tick("uni");
    send_en = '0;
    chk("uni.early", W'(recv_en), '0);
    tick("uni");
    chk("uni.en", W'(recv_en), W'(8'h02));
    chk("uni.word", recv_word[1*W +: W], W'(8'hA5));
    flush();

    // Multicast stall with a held receiver.
    subscribe(2, 5);
    subscribe(3, 5);
    recv_rdy = 8'b0000_0100;
    for (int k = 0; k < 6; k++) begin
      push(5, W'(k + 32'h100));
      tick("stall");
      if (k == 4) chk("stall.send_rdy5", W'(send_rdy[5]), '0);
    end
    send_en = '0;
    chk("stall.ovf5", W'(ovf[5]), W'(1'b1));
    for (int k = 0; k < 4; k++) tick("stall.hold");
    recv_rdy = '1;
    for (int k = 0; k < 12; k++) tick("stall.drain");
    flush();

    // Full-rate throughput.
    subscribe(7, 3);
    recv_rdy = '1;
    cnt = 0;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        words[k] = rnd_word();
        push(3, words[k]);
      end else begin
        send_en = '0;
      end
      tick("thru");
      if (recv_en[7]) begin
        if (cnt < 16) chk("thru.order", recv_word[7*W +: W], words[cnt]);
        cnt++;
      end
    end
    chk("thru.count", W'(cnt), W'(16));
    flush();

    // Held head with no subscriber.
    push(2, W'(8'h11));
    recv_rdy = '1;
    tick("nosub");
    send_en = '0;
    for (int k = 0; k < 10; k++) tick("nosub.wait");
    chk("nosub.rdy2", W'(send_rdy[2]), W'(1'b1));
    subscribe(4, 2);
    tick("nosub.sub");
    chk("nosub.en4", W'(recv_en[4]), W'(1'b1));
    chk("nosub.word", recv_word[4*W +: W], W'(8'h11));
    flush();

    // Flush of a full FIFO with a simultaneous push.
    for (int k = 0; k < 5; k++) begin
      push(0, rnd_word());
      tick("clr.fill");
    end
    ic_clr = 1'b1;
    tick("clr");
    ic_clr  = 1'b0;
    send_en = '0;
    chk("clr.send_rdy", W'(send_rdy), W'(8'hFF));
    chk("clr.ovf", W'(ovf), '0);
    subscribe(0, 0);
    recv_rdy = '1;
    for (int k = 0; k < 4; k++) tick("clr.after");
    chk("clr.nodeliver", W'(recv_en), '0);
    idle_inputs();

    // Randomised traffic with reconfiguration, flushes and a mid-burst reset.
    for (int c = 0; c < 1500; c++) begin
      send_en  = N'($urandom());
      recv_rdy = N'($urandom() | $urandom());
      for (int i = 0; i < N; i++) send_word[i*W +: W] = rnd_word();
      if ($urandom_range(0, 7) == 0) begin
        int j;
        j = $urandom_range(0, N - 1);
        recv_on[j]          = ($urandom_range(0, 3) != 0);
        recv_from[j*B +: B] = B'($urandom_range(0, N - 1));
      end
      ic_clr = ($urandom_range(0, 299) == 0);
      if (c == 700) begin
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst.recv_en", W'(recv_en), '0);
        chk("rst.send_rdy", W'(send_rdy), W'(8'hFF));
        chk("rst.ovf", W'(ovf), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
